// File: rtl/ad_cfg_pkg.sv
// Shared constants and types for the AD configuration bank.
package ad_cfg_pkg;

  // Largest supported channel count.
  localparam int unsigned MaxChNum = 8;

  // Global register offsets.
  localparam logic [7:0] OffModId  = 8'h00;
  localparam logic [7:0] OffChNum  = 8'h01;
  localparam logic [7:0] OffCommit = 8'h08;
  localparam logic [7:0] OffErr    = 8'h0C;
  localparam logic [7:0] OffPend   = 8'h0D;

  // Channel windows start at ChBase and repeat every ChStride bytes.
  localparam logic [7:0] ChBase    = 8'h20;
  localparam logic [7:0] ChStride  = 8'h10;
  localparam logic [3:0] ChBaseIdx = 4'(ChBase / ChStride);

  // Field offsets within a channel window.
  localparam logic [3:0] FldSample = 4'h0;
  localparam logic [3:0] FldAdTp   = 4'h1;
  localparam logic [3:0] FldBase0  = 4'h4;
  localparam logic [3:0] FldBase1  = 4'h5;
  localparam logic [3:0] FldBase2  = 4'h6;
  localparam logic [3:0] FldStep   = 4'h7;

  // Optional debug scratch window.
  localparam logic [7:0]  DbgBase = 8'hF0;
  localparam int unsigned DbgNum  = 8;
  localparam logic [7:0]  DbgRst  = 8'h80;

  // Reset values for every channel's shadow and active sets.
  localparam logic [7:0]  RstSample = 8'd20;
  localparam logic [7:0]  RstAdTp   = 8'd0;
  localparam logic [23:0] RstTpBase = 24'd0;
  localparam logic [7:0]  RstTpStep = 8'd1;

  typedef struct packed {
    logic [7:0]  sample;
    logic [7:0]  ad_tp;
    logic [23:0] tp_base;
    logic [7:0]  tp_step;
  } chan_cfg_t;

  localparam chan_cfg_t ChanCfgRst = '{
    sample:  RstSample,
    ad_tp:   RstAdTp,
    tp_base: RstTpBase,
    tp_step: RstTpStep
  };

endpackage

// File: rtl/ad_cfg_chan.sv
// One channel of the AD configuration bank: shadow set, active set, pending flag,
// commit / update-pulse logic and the shadow read mux.
module ad_cfg_chan
  import ad_cfg_pkg::*;
#(
  parameter bit AutoCommit = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [3:0]  wfld_i,
  input  logic [7:0]  wdata_i,
  input  logic        rd_i,
  input  logic [3:0]  rfld_i,
  input  logic        commit_i,
  output logic [7:0]  sample_o,
  output logic [7:0]  ad_tp_o,
  output logic [23:0] tp_base_o,
  output logic [7:0]  tp_step_o,
  output logic        upd_o,
  output logic        pending_o,
  output logic [7:0]  rdata_o
);

  chan_cfg_t shadow_q, shadow_d;
  chan_cfg_t active_q, active_d;
  logic      pending_q, pending_d;
  logic      upd_q, upd_d;
  logic      wr_hit;
  logic      do_commit;

  // Shadow writes, pending tracking and commit into the active set.
  always_comb begin
    shadow_d = shadow_q;
    wr_hit   = 1'b0;
    if (wr_i) begin
      wr_hit = 1'b1;
      case (wfld_i)
        FldSample: shadow_d.sample          = wdata_i;
        FldAdTp:   shadow_d.ad_tp           = wdata_i;
        FldBase0:  shadow_d.tp_base[7:0]    = wdata_i;
        FldBase1:  shadow_d.tp_base[15:8]   = wdata_i;
        FldBase2:  shadow_d.tp_base[23:16]  = wdata_i;
        FldStep:   shadow_d.tp_step         = wdata_i;
        default:   wr_hit = 1'b0;
      endcase
    end

    // Auto mode commits on the cycle after the write, when pending is visible.
    do_commit = pending_q && (commit_i || AutoCommit);
    active_d  = do_commit ? shadow_q : active_q;
    upd_d     = do_commit;

    // A write landing together with a commit keeps the channel pending.
    pending_d = pending_q;
    if (do_commit) pending_d = 1'b0;
    if (wr_hit)    pending_d = 1'b1;
  end

  // Channel state; reset discards anything pending without an update pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= ChanCfgRst;
      active_q  <= ChanCfgRst;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
    end
  end

  // Shadow read mux, zero when not selected or offset undefined.
  always_comb begin
    rdata_o = 8'd0;
    if (rd_i) begin
      case (rfld_i)
        FldSample: rdata_o = shadow_q.sample;
        FldAdTp:   rdata_o = shadow_q.ad_tp;
        FldBase0:  rdata_o = shadow_q.tp_base[7:0];
        FldBase1:  rdata_o = shadow_q.tp_base[15:8];
        FldBase2:  rdata_o = shadow_q.tp_base[23:16];
        FldStep:   rdata_o = shadow_q.tp_step;
        default:   rdata_o = 8'd0;
      endcase
    end
  end

  assign sample_o  = active_q.sample;
  assign ad_tp_o   = active_q.ad_tp;
  assign tp_base_o = active_q.tp_base;
  assign tp_step_o = active_q.tp_step;
  assign upd_o     = upd_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/ad_cfg_bank.sv
// Multi-channel AD configuration register bank on the fx bus.
// Holds address decode, global registers, sticky error flags and the read-data combine.
// Optional macro AD_CFG_DBG_EN adds eight debug scratch registers at 0xF0..0xF7.
module ad_cfg_bank
  import ad_cfg_pkg::*;
#(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned AUTO_COMMIT = 0
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic [5:0]           mod_id,
  input  logic                 fx_wr,
  input  logic [15:0]          fx_waddr,
  input  logic [7:0]           fx_data,
  input  logic                 fx_rd,
  input  logic [15:0]          fx_raddr,
  output logic [7:0]           fx_q,
  output logic                 fx_qv,
  input  logic [CH_NUM-1:0]    ad_err,
  output logic [CH_NUM*8-1:0]  cfg_sample,
  output logic [CH_NUM*8-1:0]  cfg_ad_tp,
  output logic [CH_NUM*24-1:0] cfg_tp_base,
  output logic [CH_NUM*8-1:0]  cfg_tp_step,
  output logic [CH_NUM-1:0]    cfg_upd,
  output logic                 err_irq
);

  if (CH_NUM < 1 || CH_NUM > MaxChNum) begin : g_bad_ch_num
    $error("ad_cfg_bank: CH_NUM must be in 1..8");
  end

  logic              wr_sel, rd_sel;
  logic [7:0]        w_off, r_off;
  logic [CH_NUM-1:0] ch_wr, ch_rd;
  logic [CH_NUM-1:0] commit_vec;
  logic [CH_NUM-1:0] pending;
  logic [CH_NUM-1:0] err_q, err_d, err_clr;
  logic              err_irq_q;
  logic [7:0]        ch_rdata [CH_NUM];
  logic [7:0]        dbg_rdata;
  logic [7:0]        rdata_d;
  logic [7:0]        fx_q_q;
  logic              fx_qv_q;
  logic [7:0]        err_rd, pend_rd;
  logic              unused_addr;

  assign unused_addr = ^{fx_waddr[15:14], fx_raddr[15:14]};

  assign wr_sel = fx_wr && (fx_waddr[13:8] == mod_id);
  assign rd_sel = fx_rd && (fx_raddr[13:8] == mod_id);
  assign w_off  = fx_waddr[7:0];
  assign r_off  = fx_raddr[7:0];

  assign commit_vec = (wr_sel && w_off == OffCommit) ? fx_data[CH_NUM-1:0] : '0;
  assign err_clr    = (wr_sel && w_off == OffErr)    ? fx_data[CH_NUM-1:0] : '0;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    // Channel windows are 16 bytes each, so bits [7:4] select the channel.
    assign ch_wr[c] = wr_sel && (w_off[7:4] == ChBaseIdx + 4'(c));
    assign ch_rd[c] = rd_sel && (r_off[7:4] == ChBaseIdx + 4'(c));

    ad_cfg_chan #(
      .AutoCommit (AUTO_COMMIT != 0)
    ) u_chan (
      .clk_i     (clk_sys),
      .rst_i     (rst),
      .wr_i      (ch_wr[c]),
      .wfld_i    (w_off[3:0]),
      .wdata_i   (fx_data),
      .rd_i      (ch_rd[c]),
      .rfld_i    (r_off[3:0]),
      .commit_i  (commit_vec[c]),
      .sample_o  (cfg_sample[c*8 +: 8]),
      .ad_tp_o   (cfg_ad_tp[c*8 +: 8]),
      .tp_base_o (cfg_tp_base[c*24 +: 24]),
      .tp_step_o (cfg_tp_step[c*8 +: 8]),
      .upd_o     (cfg_upd[c]),
      .pending_o (pending[c]),
      .rdata_o   (ch_rdata[c])
    );
  end

  // Sticky errors: a new event wins over a same-cycle clear.
  always_comb begin
    err_d = (err_q & ~err_clr) | ad_err;
  end

  // Error flags and the interrupt, which lags the flags by one cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      err_q     <= '0;
      err_irq_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      err_irq_q <= |err_q;
    end
  end

`ifdef AD_CFG_DBG_EN
  logic [7:0] dbg_q [DbgNum];
  logic [7:0] dbg_d [DbgNum];

  // Debug scratch writes.
  always_comb begin
    for (int i = 0; i < DbgNum; i++) dbg_d[i] = dbg_q[i];
    if (wr_sel && w_off[7:3] == DbgBase[7:3]) dbg_d[w_off[2:0]] = fx_data;
  end

  // Debug scratch storage with distinct reset patterns.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < DbgNum; i++) dbg_q[i] <= DbgRst + 8'(i);
    end else begin
      dbg_q <= dbg_d;
    end
  end

  assign dbg_rdata = (rd_sel && r_off[7:3] == DbgBase[7:3]) ? dbg_q[r_off[2:0]] : 8'd0;
`else
  assign dbg_rdata = 8'd0;
`endif

  // Read data: global registers plus the OR of the already-gated channel muxes.
  always_comb begin
    err_rd               = 8'd0;
    pend_rd              = 8'd0;
    err_rd[CH_NUM-1:0]   = err_q;
    pend_rd[CH_NUM-1:0]  = pending;
    rdata_d              = dbg_rdata;
    if (rd_sel) begin
      case (r_off)
        OffModId: rdata_d = rdata_d | {2'b00, mod_id};
        OffChNum: rdata_d = rdata_d | 8'(CH_NUM);
        OffErr:   rdata_d = rdata_d | err_rd;
        OffPend:  rdata_d = rdata_d | pend_rd;
        default:  ;
      endcase
    end
    for (int c = 0; c < CH_NUM; c++) rdata_d = rdata_d | ch_rdata[c];
  end

  // Registered read port.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      fx_q_q  <= 8'd0;
      fx_qv_q <= 1'b0;
    end else begin
      fx_q_q  <= rdata_d;
      fx_qv_q <= rd_sel;
    end
  end

  assign fx_q    = fx_q_q;
  assign fx_qv   = fx_qv_q;
  assign err_irq = err_irq_q;

endmodule

// File: tb/tb_ad_cfg_bank.sv
// Scoreboard bench for ad_cfg_bank: reads push expected data, a monitor pops on fx_qv.
module tb_ad_cfg_bank;

  localparam int unsigned Ch = 4;
  localparam logic [5:0]  Mod = 6'h05;

  logic            clk_sys = 1'b0;
  logic            rst = 1'b1;
  logic [5:0]      mod_id = Mod;
  logic            fx_wr = 1'b0;
  logic [15:0]     fx_waddr = '0;
  logic [7:0]      fx_data = '0;
  logic            fx_rd = 1'b0;
  logic [15:0]     fx_raddr = '0;
  logic [Ch-1:0]   ad_err = '0;

  logic [7:0]      fx_q, a_fx_q;
  logic            fx_qv, a_fx_qv;
  logic [Ch*8-1:0] cfg_sample, cfg_ad_tp, cfg_tp_step;
  logic [Ch*8-1:0] a_sample, a_ad_tp, a_tp_step;
  logic [Ch*24-1:0] cfg_tp_base, a_tp_base;
  logic [Ch-1:0]   cfg_upd, a_upd;
  logic            err_irq, a_err_irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
    string      name;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  ad_cfg_bank #(.CH_NUM(Ch), .AUTO_COMMIT(0)) dut (
    .clk_sys(clk_sys), .rst(rst), .mod_id(mod_id),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .fx_qv(fx_qv),
    .ad_err(ad_err), .cfg_sample(cfg_sample), .cfg_ad_tp(cfg_ad_tp),
    .cfg_tp_base(cfg_tp_base), .cfg_tp_step(cfg_tp_step),
    .cfg_upd(cfg_upd), .err_irq(err_irq)
  );

  ad_cfg_bank #(.CH_NUM(Ch), .AUTO_COMMIT(1)) dut_auto (
    .clk_sys(clk_sys), .rst(rst), .mod_id(mod_id),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(a_fx_q), .fx_qv(a_fx_qv),
    .ad_err(ad_err), .cfg_sample(a_sample), .cfg_ad_tp(a_ad_tp),
    .cfg_tp_base(a_tp_base), .cfg_tp_step(a_tp_step),
    .cfg_upd(a_upd), .err_irq(a_err_irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented read against the scoreboard head.
  always @(negedge clk_sys) begin
    if (fx_qv) begin
      if (exp_q.size() == 0) begin
        check("unexpected_qv", 64'(fx_q), 64'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_data"}, 64'(fx_q), 64'(e.data));
        check({e.name, "_lat"}, 64'(cyc), 64'(e.due));
      end
    end else begin
      check("idle_q_zero", 64'(fx_q), 64'h0);
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_missing_qv"}, 64'(fx_qv), 64'h1);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d, input logic [5:0] id = Mod);
    fx_wr = 1'b1; fx_waddr = {2'b00, id, off}; fx_data = d;
    step();
    fx_wr = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] off, input logic [7:0] exp);
    fx_rd = 1'b1; fx_raddr = {2'b00, Mod, off};
    exp_q.push_back('{data: exp, due: cyc + 1, name: name});
    step();
    fx_rd = 1'b0;
  endtask

  // Read and write the same register in one cycle; the read sees the old value.
  task automatic rw(input string name, input logic [7:0] off, input logic [7:0] d,
                    input logic [7:0] exp);
    fx_wr = 1'b1; fx_waddr = {2'b00, Mod, off}; fx_data = d;
    fx_rd = 1'b1; fx_raddr = {2'b00, Mod, off};
    exp_q.push_back('{data: exp, due: cyc + 1, name: name});
    step();
    fx_wr = 1'b0; fx_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset defaults
    step(3);
    rst = 1'b0;
    check("rst_sample", 64'(cfg_sample), 64'h14141414);
    check("rst_step", 64'(cfg_tp_step), 64'h01010101);
    check("rst_tp", 64'(cfg_ad_tp), 64'h0);
    check("rst_base_lo", cfg_tp_base[63:0], 64'h0);
    check("rst_upd", 64'(cfg_upd), 64'h0);
    check("rst_irq", 64'(err_irq), 64'h0);
    check("rst_qv", 64'(fx_qv), 64'h0);
    rd("rd_sample0", 8'h20, 8'd20);
    rd("rd_adtp0", 8'h21, 8'd0);
    rd("rd_step0", 8'h27, 8'd1);
    rd("rd_modid", 8'h00, 8'h05);
    rd("rd_chnum", 8'h01, 8'd4);

    // Commit with nothing pending
    wr(8'h08, 8'h0F);
    check("nopend_upd", 64'(cfg_upd), 64'h0);
    step();
    check("nopend_upd2", 64'(cfg_upd), 64'h0);
    rd("rd_commit_reg", 8'h08, 8'h00);

    // Atomic base update on channel 1
    wr(8'h34, 8'h11);
    wr(8'h35, 8'h22);
    check("base_mid", 64'(cfg_tp_base[47:24]), 64'h0);
    wr(8'h36, 8'h33);
    check("base_pre", 64'(cfg_tp_base[47:24]), 64'h0);
    rd("rd_shadow_b0", 8'h34, 8'h11);
    rd("rd_shadow_b2", 8'h36, 8'h33);
    rd("rd_pend_1", 8'h0D, 8'h02);
    check("base_still", 64'(cfg_tp_base[47:24]), 64'h0);
    wr(8'h08, 8'h02);
    check("base_post", 64'(cfg_tp_base[47:24]), 64'h332211);
    check("upd_pulse", 64'(cfg_upd), 64'h2);
    step();
    check("upd_gone", 64'(cfg_upd), 64'h0);
    rd("rd_pend_0", 8'h0D, 8'h00);

    // Sticky error
    ad_err = 4'b0100;
    step();
    ad_err = 4'b0000;
    check("irq_lag", 64'(err_irq), 64'h0);
    step();
    check("irq_set", 64'(err_irq), 64'h1);
    rd("rd_err_set", 8'h0C, 8'h04);
    ad_err = 4'b0100;
    wr(8'h0C, 8'h04);
    ad_err = 4'b0000;
    rd("rd_err_setwins", 8'h0C, 8'h04);
    check("irq_hold", 64'(err_irq), 64'h1);
    wr(8'h0C, 8'h04);
    rd("rd_err_clr", 8'h0C, 8'h00);
    check("irq_drop", 64'(err_irq), 64'h0);

    // Decode: foreign module id, absent channel, undefined and debug offsets
    wr(8'h20, 8'h99, 6'h06);
    rd("rd_foreign", 8'h20, 8'd20);
    wr(8'h70, 8'hAB);
    rd("rd_ch5", 8'h70, 8'h00);
    wr(8'h22, 8'h5A);
    rd("rd_undef", 8'h22, 8'h00);
    rd("rd_dbg", 8'hF0, 8'h00);
    rd("rd_pend_none", 8'h0D, 8'h00);
    check("decode_sample", 64'(cfg_sample), 64'h14141414);
    fx_rd = 1'b1; fx_raddr = {2'b00, 6'h06, 8'h00};
    step();
    fx_rd = 1'b0;

    // Read-during-write returns the old shadow value
    rw("rd_rw_old", 8'h20, 8'h55, 8'd20);
    rd("rd_rw_new", 8'h20, 8'h55);
    check("rw_active", 64'(cfg_sample[7:0]), 64'd20);

    // Reset with a pending commit
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_upd", 64'(cfg_upd), 64'h0);
    rd("rd_rst_pend", 8'h0D, 8'h00);
    rd("rd_rst_sample", 8'h20, 8'd20);
    check("rst_mid_base", 64'(cfg_tp_base[47:24]), 64'h0);

    // Auto-commit instance
    wr(8'h27, 8'h05);
    check("auto_n1_step", 64'(a_tp_step[7:0]), 64'd1);
    check("auto_n1_upd", 64'(a_upd), 64'h0);
    step();
    check("auto_n2_step", 64'(a_tp_step[7:0]), 64'd5);
    check("auto_n2_upd", 64'(a_upd), 64'h1);
    step();
    check("auto_n3_upd", 64'(a_upd), 64'h0);
    check("manual_unchanged", 64'(cfg_tp_step[7:0]), 64'd1);

    step(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
